// File: rtl/otter_mem_arbiter_if.sv
// otter_mem_arbiter_if: fetch, data and backing-memory handshake bundle around the arbiter
interface otter_mem_arbiter_if;
    logic        IF_REQ;
    logic [31:0] IF_ADDR;
    logic        IF_GNT;
    logic        IF_RVALID;
    logic [31:0] IF_RDATA;
    logic        D_REQ;
    logic        D_WE;
    logic [31:0] D_ADDR;
    logic [31:0] D_WDATA;
    logic [1:0]  D_SIZE;
    logic        D_GNT;
    logic        D_RVALID;
    logic [31:0] D_RDATA;
    logic        M_REQ;
    logic        M_WE;
    logic [31:0] M_ADDR;
    logic [31:0] M_WDATA;
    logic [1:0]  M_SIZE;
    logic        M_READY;
    logic        M_RVALID;
    logic [31:0] M_RDATA;

    modport slave (
        input  IF_REQ, IF_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, D_SIZE, M_READY, M_RVALID, M_RDATA,
        output IF_GNT, IF_RVALID, IF_RDATA, D_GNT, D_RVALID, D_RDATA, M_REQ, M_WE, M_ADDR, M_WDATA, M_SIZE
    );

    modport master (
        output IF_REQ, IF_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, D_SIZE, M_READY, M_RVALID, M_RDATA,
        input  IF_GNT, IF_RVALID, IF_RDATA, D_GNT, D_RVALID, D_RDATA, M_REQ, M_WE, M_ADDR, M_WDATA, M_SIZE
    );
endinterface

// File: rtl/otter_mem_arbiter.sv
// otter_mem_arbiter: shares one handshaked memory between OTTER fetch and data ports
module otter_mem_arbiter #(
    parameter int MAX_STREAK = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                CLK,
    input  logic                RST_N,
    otter_mem_arbiter_if.slave  bus,
    output logic                BUSY,
    output logic                ERR
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t      state, state_nxt;
    logic        owner_d, owner_nxt;
    logic [3:0]  streak, streak_nxt;
    logic [7:0]  wait_cnt, wait_cnt_nxt;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic        gnt_d, gnt_f, rvalid;
    logic [31:0] rdata;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            owner_d  <= 1'b0;
            streak   <= '0;
            wait_cnt <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= '0;
            we_q     <= 1'b0;
        end else begin
            state    <= state_nxt;
            owner_d  <= owner_nxt;
            streak   <= streak_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (gnt_d || gnt_f) begin
                addr_q  <= gnt_d ? bus.D_ADDR : bus.IF_ADDR;
                wdata_q <= bus.D_WDATA;
                size_q  <= gnt_d ? bus.D_SIZE : 2'd2;
                we_q    <= gnt_d && bus.D_WE;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner_d;
        streak_nxt   = streak;
        wait_cnt_nxt = wait_cnt;
        gnt_d        = 1'b0;
        gnt_f        = 1'b0;
        rvalid       = 1'b0;
        rdata        = '0;
        ERR          = 1'b0;
        unique case (state)
            IDLE: begin
                // grants are gated by RST_N so nothing leaks out while reset is held
                gnt_d = RST_N && bus.D_REQ && !(bus.IF_REQ && streak == 4'(MAX_STREAK));
                gnt_f = RST_N && bus.IF_REQ && !gnt_d;
                streak_nxt = (gnt_f || !bus.IF_REQ) ? 4'd0 :
                             (gnt_d && streak != 4'hf) ? streak + 4'd1 : streak;
                if (gnt_d || gnt_f) begin
                    state_nxt = REQ;
                    owner_nxt = gnt_d;
                end
            end
            REQ: if (bus.M_READY) begin
                rvalid       = we_q;
                state_nxt    = we_q ? IDLE : WAIT;
                wait_cnt_nxt = '0;
            end
            WAIT: if (bus.M_RVALID) begin
                rvalid    = 1'b1;
                rdata     = bus.M_RDATA;
                state_nxt = IDLE;
            end else if (TIMEOUT != 0 && wait_cnt == 8'(TIMEOUT - 1)) begin
                rvalid    = 1'b1;
                ERR       = 1'b1;
                state_nxt = IDLE;
            end else begin
                wait_cnt_nxt = wait_cnt + 8'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign BUSY          = state != IDLE;
    assign bus.IF_GNT    = gnt_f;
    assign bus.D_GNT     = gnt_d;
    assign bus.IF_RVALID = rvalid && !owner_d;
    assign bus.D_RVALID  = rvalid && owner_d;
    assign bus.IF_RDATA  = bus.IF_RVALID ? rdata : '0;
    assign bus.D_RDATA   = bus.D_RVALID ? rdata : '0;
    assign bus.M_REQ     = state == REQ;
    assign bus.M_WE      = bus.M_REQ && we_q;
    assign bus.M_ADDR    = bus.M_REQ ? addr_q : '0;
    assign bus.M_WDATA   = bus.M_REQ ? wdata_q : '0;
    assign bus.M_SIZE    = bus.M_REQ ? size_q : '0;
endmodule

// File: doc/otter_mem_arbiter.md
Name: otter_mem_arbiter

Overview:
- Shares one single-ported, handshaked backing memory between the OTTER instruction-fetch port and the MEM-stage data port.
- Holds at most one outstanding transaction.
- Arbitrates with data priority and a fetch starvation guard.
- Enforces a response timeout and exposes BUSY so the pipeline can stall fetch/memory stages while a transaction is in flight.

Parameters:
- MAX_STREAK, 4, consecutive data grants allowed while IF_REQ is pending before fetch is forced a grant (1..15).
- TIMEOUT, 16, max cycles in WAIT before abort; 0 disables the timeout (max 255).

Ports:
- CLK in 1 system clock, rising edge
- RST_N in 1 reset, asynchronous, active-low
- IF_REQ in 1 fetch request, held until IF_GNT
- IF_ADDR in 32 fetch byte address
- IF_GNT out 1 fetch accepted this cycle
- IF_RVALID out 1 fetch data valid (one-cycle pulse)
- IF_RDATA out 32 fetch data
- D_REQ in 1 data request, held until D_GNT
- D_WE in 1 1=store, 0=load
- D_ADDR in 32 data byte address
- D_WDATA in 32 store data
- D_SIZE in 2 0=byte, 1=half, 2=word
- D_GNT out 1 data request accepted this cycle
- D_RVALID out 1 load data valid, or store complete (one-cycle pulse)
- D_RDATA out 32 load data
- M_REQ out 1 memory request
- M_WE out 1 memory write enable
- M_ADDR out 32 memory address
- M_WDATA out 32 memory write data
- M_SIZE out 2 memory access size
- M_READY in 1 memory accepted request
- M_RVALID in 1 memory read data valid
- M_RDATA in 32 memory read data
- BUSY out 1 state != IDLE
- ERR out 1 one-cycle pulse on timeout abort

Behaviour:
- Reset (RST_N low, asynchronous):
  - State = IDLE; owner = fetch; streak = 0; wait counter = 0.
  - Latched address/data/size/we = 0.
  - All outputs 0.
- States:
  - IDLE: no transaction in flight.
  - REQ: M_REQ held with latched fields until M_READY.
  - WAIT: waiting for read data.
- IDLE arbitration (combinational GNT, both GNTs low outside IDLE):
  - D_REQ only -> data.
  - IF_REQ only -> fetch.
  - Both -> data, unless streak == MAX_STREAK, then fetch.
  - Winner's GNT is high this cycle. At the clock edge: latch addr/wdata/size/we (fetch forces we=0, size=2), record owner, go to REQ.
- Streak counter:
  - +1 (saturating at 15) on a data grant while IF_REQ = 1.
  - Cleared on a fetch grant, or on any IDLE cycle where IF_REQ = 0.
- REQ state:
  - M_REQ = 1 with latched fields; fields are stable until M_READY.
  - M_READY and we=1 -> D_RVALID = 1 in the same cycle (combinational); next state IDLE.
  - M_READY and we=0 -> WAIT; wait counter cleared.
- WAIT state:
  - M_RVALID -> owner's RVALID = 1 and RDATA = M_RDATA (combinational, same cycle); next state IDLE.
  - Otherwise the counter increments. When counter == TIMEOUT-1 with no M_RVALID: ERR = 1, owner's RVALID = 1 with RDATA = 0, next state IDLE.
- Non-owner RVALID is always 0. RDATA outputs are 0 when their RVALID = 0.
- Stray M_RVALID in IDLE or REQ is ignored.
- Minimum load/fetch latency: GNT in cycle 0, M_REQ in cycle 1, M_RVALID earliest in cycle 2, IDLE in cycle 3. The next grant is therefore possible in cycle 3; there is no back-to-back issue.
- Requests arriving while BUSY are held by the requester and are not granted until IDLE.
- Asserting RST_N low mid-transaction aborts it immediately. No RVALID or ERR is produced, and the memory sees M_REQ drop asynchronously.
- Address is passed through unmodified. Alignment is the memory's responsibility.

Test Plan:
- Reset: hold RST_N=0 with IF_REQ=D_REQ=1 -> all outputs 0, BUSY=0. Release -> D_GNT=1 in the first IDLE cycle.
- Single fetch: IF_REQ, IF_ADDR=0x100; M_READY=1 immediately; M_RVALID one cycle later with M_RDATA=0xDEADBEEF -> M_ADDR=0x100, M_WE=0, M_SIZE=2; IF_RVALID pulses with 0xDEADBEEF exactly 2 cycles after IF_GNT.
- Store: D_REQ, D_WE=1, D_ADDR=0x8000, D_WDATA=0x12345678, D_SIZE=0; M_READY delayed 3 cycles -> M_REQ and fields stable for 4 cycles; D_RVALID pulses in the M_READY cycle; no WAIT state entered.
- Starvation guard (MAX_STREAK=4): IF_REQ and D_REQ held high continuously -> grant order D,D,D,D,F,D,D,D,D,F; streak resets after each fetch grant.
- Timeout (TIMEOUT=16): load granted, M_READY=1, M_RVALID never -> after 16 WAIT cycles ERR=1, D_RVALID=1, D_RDATA=0; BUSY=0 next cycle. A late M_RVALID arriving afterwards is ignored.
- Mid-op reset: drop RST_N during WAIT of a fetch -> BUSY and M_REQ fall without waiting for CLK. After release, the pending IF_REQ is regranted and no IF_RVALID is produced for the aborted fetch.
